countdown_core: RTL and testbench
=================================

// Module: countdown_core
// PURPOSE
//  Binary countdown engine of the timer: loads a preset, decrements it once per
//  prescaled tick, and supports start/pause/resume. Signals expiry.
//  count feeds the binary-to-BCD converter directly, which then drives the display.
// PARAMETERS
//  BIN_WIDTH  8           width of count/load_val; matches the BCD converter's BIN_WIDTH
//  MAX_COUNT  99          largest loadable value; must be < 2**BIN_WIDTH
//  TICK_DIV   50_000_000  clk cycles per decrement (1 s at 50 MHz); must be >= 2
// PORTS
//  clk         in   1          system clock, all logic on rising edge
//  rst_n       in   1          asynchronous, active-low reset
//  load        in   1          1-cycle pulse: load preset, go IDLE
//  load_val    in   BIN_WIDTH  preset value sampled when load=1
//  start       in   1          1-cycle pulse: start / pause / resume toggle
//  count       out  BIN_WIDTH  current remaining count, registered
//  running     out  1          1 while state==RUN
//  done        out  1          level, 1 while state==DONE
//  done_pulse  out  1          1-cycle pulse on the RUN->DONE transition
// BEHAVIOUR
//  - Reset (async assert, sync-released by top level): state=IDLE, count=0,
//    prescaler=0, running=0, done=0, done_pulse=0.
//  - Inputs are already debounced, synchronous, single-cycle pulses.
//  - tick = (state==RUN) && (prescaler==TICK_DIV-1). The prescaler counts only in
//    RUN and wraps to 0 on tick. It holds its value in PAUSED and clears on load
//    and on IDLE->RUN.
//  - The load value is clamped: count <= (load_val > MAX_COUNT) ? MAX_COUNT : load_val.
//  - FSM states: IDLE, RUN, PAUSED, DONE. Priority: load > tick/start.
//    IDLE:   load -> IDLE with the new count. start with count!=0 -> RUN.
//            start with count==0 is ignored.
//    RUN:    tick -> count-1. If count==1 at tick: count=0, -> DONE, done_pulse=1.
//            start -> PAUSED. start and tick together: decrement applies; DONE wins
//            over PAUSED when count reaches 0.
//            load -> IDLE with the new count (abort).
//    PAUSED: start -> RUN, prescaler resumes from its held value. load -> IDLE.
//    DONE:   count stays 0. start is ignored. load -> IDLE with the new count.
//  - Latency: count, state and flags change on the clk edge after the causing
//    condition (1 cycle). done_pulse is high for exactly one cycle. count never
//    underflows or wraps.
//  - Reset mid-operation: immediate return to reset values. No pulse is emitted.
// STRUCTURE
//  - countdown_pkg: typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} cd_state_t.
//    Shared with the top level / display blanking logic.
//  - Sub-module tick_prescaler (TICK_DIV): inputs en, clr; output tick.
//    Counter width $clog2(TICK_DIV).
//  - Top level: state register, count register with clamp/decrement mux,
//    done_pulse register.
// TESTING  (bench uses TICK_DIV=4, MAX_COUNT=99, BIN_WIDTH=8)
//  1. Reset, then load 3 and start -> count 3,2,1,0 at 4-cycle spacing.
//     done_pulse is 1 for one cycle with count=0. done stays 1. running=0 after.
//  2. load_val=200 -> count=99 (clamp). load_val=0 then start -> stays IDLE,
//     running=0, done=0.
//  3. Load 5, start, pause after 6 cycles (count=4, prescaler=1), wait 20 cycles
//     -> count holds 4. Resume -> next decrement 3 cycles later (prescaler retained).
//  4. Count=1 with start and tick in the same cycle -> count=0, state DONE
//     (not PAUSED), done_pulse=1.
//  5. In RUN at count=7, pulse load with 42 together with start -> count=42, IDLE,
//     prescaler=0. Start in DONE -> ignored. load 10 in DONE -> IDLE, count=10.
//  6. Assert rst_n=0 mid-RUN, asynchronously between edges -> outputs go to reset
//     values before the next clk edge. No done_pulse.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer.
// cd_state_t is also used by the top level / display blanking logic.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } cd_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler that divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// Ports:
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset
//   en    in   count enable; the counter holds its value while low
//   clr   in   synchronous clear, overrides en
//   tick  out  high for the enabled cycle in which the counter is at TICK_DIV-1
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick = en && (cnt_q == LAST);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_core.sv
// Binary countdown engine: loads a clamped preset, decrements once per prescaled tick,
// and supports start/pause/resume. Signals expiry as a level and a one-cycle pulse.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   load       in   pulse: load preset (clamped to MAX_COUNT), go IDLE
//   load_val   in   preset value sampled with load
//   start      in   pulse: start / pause / resume toggle
//   count      out  remaining count, registered
//   running    out  high while in RUN
//   done       out  high while in DONE
//   done_pulse out  one-cycle pulse on RUN->DONE
module countdown_core
    import countdown_pkg::*;
#(
    parameter int unsigned BIN_WIDTH = 8,
    parameter int unsigned MAX_COUNT = 99,
    parameter int unsigned TICK_DIV  = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [BIN_WIDTH-1:0] load_val,
    input  logic                 start,
    output logic [BIN_WIDTH-1:0] count,
    output logic                 running,
    output logic                 done,
    output logic                 done_pulse
);

    localparam logic [BIN_WIDTH-1:0] MAX_VAL = BIN_WIDTH'(MAX_COUNT);
    localparam logic [BIN_WIDTH-1:0] ONE     = BIN_WIDTH'(1);

    cd_state_t            state_q, state_d;
    logic [BIN_WIDTH-1:0] count_q, count_d;
    logic                 done_pulse_q, done_pulse_d;

    logic                 tick;
    logic                 presc_clr;
    logic [BIN_WIDTH-1:0] load_clamped;

    always_comb begin
        load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        // Prescaler restarts on every load and on each fresh IDLE->RUN start,
        // but keeps its phase across a pause.
        presc_clr    = load || ((state_q == IDLE) && start && (count_q != '0));
    end

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == RUN),
        .clr   (presc_clr),
        .tick  (tick)
    );

    // State, count and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    // Next-state logic; load overrides everything else
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        done_pulse_d = 1'b0;
        if (load) begin
            state_d = IDLE;
            count_d = load_clamped;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && (count_q != '0)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tick && (count_q != '0)) begin
                        count_d = count_q - ONE;
                        // Expiry beats a simultaneous pause request
                        if (count_q == ONE) begin
                            state_d      = DONE;
                            done_pulse_d = 1'b1;
                        end else if (start) begin
                            state_d = PAUSED;
                        end
                    end else if (start) begin
                        state_d = PAUSED;
                    end
                end
                PAUSED: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        count      = count_q;
        running    = (state_q == RUN);
        done       = (state_q == DONE);
        done_pulse = done_pulse_q;
    end

endmodule

// File: tb/tb_countdown_core.sv
module tb_countdown_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       start = 1'b0;
    logic [7:0] count;
    logic       running;
    logic       done;
    logic       done_pulse;

    always #5 clk = ~clk;

    countdown_core #(
        .BIN_WIDTH (8),
        .MAX_COUNT (99),
        .TICK_DIV  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .count      (count),
        .running    (running),
        .done       (done),
        .done_pulse (done_pulse)
    );

    typedef struct {
        logic       ld;
        logic [7:0] val;
        logic       st;
        int         reps;
        logic [7:0] c;
        logic       r;
        logic       d;
        logic       p;
    } vec_t;

    typedef struct {
        int         row;
        logic [7:0] c;
        logic       r;
        logic       d;
        logic       p;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    function automatic void add(input logic ld, input logic [7:0] val, input logic st,
                                input int reps, input logic [7:0] c, input logic r,
                                input logic d, input logic p);
        vec_t v;
        v.ld = ld; v.val = val; v.st = st; v.reps = reps;
        v.c = c; v.r = r; v.d = d; v.p = p;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] ec, input logic er,
                         input logic ed, input logic ep);
        checks++;
        if (count !== ec || running !== er || done !== ed || done_pulse !== ep) begin
            failures++;
            $display("FAIL %s: got count=%0d running=%b done=%b done_pulse=%b, want count=%0d running=%b done=%b done_pulse=%b",
                     name, count, running, done, done_pulse, ec, er, ed, ep);
        end
    endtask

    initial begin
        exp_t e;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset", 8'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        //  ld  val  st reps  cnt run done pulse  (outputs after the edge)
        // Load 3, run down at 4-cycle spacing to DONE
        add(1, 3,   0, 1,  3,  0, 0, 0);
        add(0, 0,   1, 1,  3,  1, 0, 0);
        add(0, 0,   0, 3,  3,  1, 0, 0);
        add(0, 0,   0, 1,  2,  1, 0, 0);
        add(0, 0,   0, 3,  2,  1, 0, 0);
        add(0, 0,   0, 1,  1,  1, 0, 0);
        add(0, 0,   0, 3,  1,  1, 0, 0);
        add(0, 0,   0, 1,  0,  0, 1, 1);
        add(0, 0,   0, 2,  0,  0, 1, 0);
        add(0, 0,   1, 1,  0,  0, 1, 0);  // start in DONE ignored
        add(0, 0,   0, 5,  0,  0, 1, 0);  // no underflow
        // Clamp and zero-start
        add(1, 200, 0, 1,  99, 0, 0, 0);
        add(1, 100, 0, 1,  99, 0, 0, 0);
        add(1, 99,  0, 1,  99, 0, 0, 0);
        add(1, 0,   0, 1,  0,  0, 0, 0);
        add(0, 0,   1, 1,  0,  0, 0, 0);
        add(0, 0,   0, 4,  0,  0, 0, 0);
        // Pause holds count and prescaler phase
        add(1, 5,   0, 1,  5,  0, 0, 0);
        add(0, 0,   1, 1,  5,  1, 0, 0);
        add(0, 0,   0, 3,  5,  1, 0, 0);
        add(0, 0,   0, 1,  4,  1, 0, 0);
        add(0, 0,   1, 1,  4,  0, 0, 0);  // pause, prescaler held at 1
        add(0, 0,   0, 20, 4,  0, 0, 0);
        add(0, 0,   1, 1,  4,  1, 0, 0);  // resume
        add(0, 0,   0, 2,  4,  1, 0, 0);
        add(0, 0,   0, 1,  3,  1, 0, 0);
        add(0, 0,   1, 1,  3,  0, 0, 0);
        add(1, 6,   0, 1,  6,  0, 0, 0);  // load from PAUSED
        // Start coincident with final tick: DONE wins
        add(1, 1,   0, 1,  1,  0, 0, 0);
        add(0, 0,   1, 1,  1,  1, 0, 0);
        add(0, 0,   0, 3,  1,  1, 0, 0);
        add(0, 0,   1, 1,  0,  0, 1, 1);
        add(0, 0,   0, 1,  0,  0, 1, 0);
        // Load + start mid-run aborts to IDLE; prescaler restarts
        add(1, 8,   0, 1,  8,  0, 0, 0);
        add(0, 0,   1, 1,  8,  1, 0, 0);
        add(0, 0,   0, 3,  8,  1, 0, 0);
        add(0, 0,   0, 1,  7,  1, 0, 0);
        add(0, 0,   0, 1,  7,  1, 0, 0);
        add(1, 42,  1, 1,  42, 0, 0, 0);
        add(0, 0,   1, 1,  42, 1, 0, 0);
        add(0, 0,   0, 3,  42, 1, 0, 0);
        add(0, 0,   0, 1,  41, 1, 0, 0);
        // Reach DONE, start ignored, load 10 leaves DONE
        add(1, 1,   0, 1,  1,  0, 0, 0);
        add(0, 0,   1, 1,  1,  1, 0, 0);
        add(0, 0,   0, 3,  1,  1, 0, 0);
        add(0, 0,   0, 1,  0,  0, 1, 1);
        add(0, 0,   1, 1,  0,  0, 1, 0);
        add(1, 10,  0, 1,  10, 0, 0, 0);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].reps; k++) begin
                load     = vecs[i].ld;
                load_val = vecs[i].val;
                start    = vecs[i].st;
                e.row = i; e.c = vecs[i].c; e.r = vecs[i].r; e.d = vecs[i].d; e.p = vecs[i].p;
                sb.push_back(e);
                @(posedge clk);
                #1;
                e = sb.pop_front();
                check($sformatf("row%0d_rep%0d", e.row, k), e.c, e.r, e.d, e.p);
            end
        end
        load  = 1'b0;
        start = 1'b0;

        // Asynchronous reset in the middle of a run
        load = 1'b1; load_val = 8'd9;
        @(posedge clk); #1;
        load = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("run_before_reset", 8'd8, 1'b1, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", 8'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("in_reset_%0d", k), 8'd0, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("after_reset_%0d", k), 8'd0, 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
